kosei_sdm_dac: RTL and testbench

Stereo first-order sigma-delta DAC back end for the Kosei audio chip. Sits directly downstream of the I2S receiver/volume stage and consumes its 16-bit signed left/right sample pairs through a valid/ready handshake into a 2-entry buffer. It pops one pair every OSR system clocks and applies a click-free soft-mute gain ramp. It drives 1-bit differential pulse-density outputs to the analog output pins.

---
 rtl/kosei_sdm_dac.sv | 204 ++++++++++++++++++++
 tb/tb_kosei_sdm_dac.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kosei_sdm_dac.sv
// Kosei stereo first-order sigma-delta DAC back end.
// Two-deep sample buffer, OSR tick, soft-mute gain ramp, PDM modulators.
module kosei_sdm_dac #(
   parameter int unsigned OSR       = 256,
   parameter int unsigned RAMP_STEP = 1
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [15:0] sample_left,
   input  logic [15:0] sample_right,
   input  logic        sample_valid,
   output logic        sample_ready,
   input  logic        underrun_clear,
   output logic        dac_left_pos,
   output logic        dac_left_neg,
   output logic        dac_right_pos,
   output logic        dac_right_neg,
   output logic        sample_tick,
   output logic [1:0]  mute_state,
   output logic [8:0]  gain,
   output logic        underrun_flag,
   output logic [7:0]  underrun_count
);

   localparam int unsigned   CW   = $clog2(OSR);
   localparam logic [CW-1:0] LAST = CW'(OSR - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [8:0]    STEP = 9'(RAMP_STEP);
   localparam logic [8:0]    FULL = 9'd256;

   typedef enum logic [1:0] {
      MUTED     = 2'd0,
      RAMP_UP   = 2'd1,
      PLAY      = 2'd2,
      RAMP_DOWN = 2'd3
   } mute_t;

   mute_t st;

   logic [CW-1:0] tick_cnt;
   logic [CW-1:0] tick_nxt;

   logic [31:0] fifo [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;
   logic        push;
   logic        pop;
   logic        starve;

   logic [15:0] cur_left;
   logic [15:0] cur_right;
   logic [15:0] acc_left;
   logic [15:0] acc_right;

   logic signed [25:0] cur_left_x;
   logic signed [25:0] cur_right_x;
   logic signed [25:0] gain_x;
   logic signed [25:0] prod_left;
   logic signed [25:0] prod_right;

   logic [15:0] scaled_left;
   logic [15:0] scaled_right;
   logic [15:0] u_left;
   logic [15:0] u_right;
   logic [16:0] sum_left;
   logic [16:0] sum_right;
   logic [9:0]  up_sum;
   logic        unused_bits;

   assign sample_ready = (count != 2'd2);
   assign push         = sample_valid && sample_ready;
   assign pop          = sample_tick && (count != 2'd0);
   assign starve       = sample_tick && (count == 2'd0);
   assign tick_nxt     = (tick_cnt == LAST) ? '0 : tick_cnt + ONE;
   assign mute_state   = st;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt    <= '0;
         sample_tick <= 1'b0;
      end else begin
         tick_cnt    <= tick_nxt;
         sample_tick <= (tick_nxt == LAST);
      end
   end

   // pop reads the older slot while a same-edge push fills the other one
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         fifo[0]   <= '0;
         fifo[1]   <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
         cur_left  <= '0;
         cur_right <= '0;
      end else begin
         if (push) begin
            fifo[wr_ptr] <= {sample_left, sample_right};
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) begin
            {cur_left, cur_right} <= fifo[rd_ptr];
            rd_ptr                <= ~rd_ptr;
         end
         count <= count + 2'(push) - 2'(pop);
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         underrun_flag  <= 1'b0;
         underrun_count <= 8'd0;
      end else if (underrun_clear) begin
         underrun_flag  <= 1'b0;
         underrun_count <= 8'd0;
      end else if (starve) begin
         underrun_flag <= 1'b1;
         if (underrun_count != 8'hFF)
            underrun_count <= underrun_count + 8'd1;
      end
   end

   assign up_sum = {1'b0, gain} + {1'b0, STEP};

   // a reversal spends its tick on the state change, gain holds
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         st   <= MUTED;
         gain <= 9'd0;
      end else if (sample_tick) begin
         unique case (st)
            MUTED: begin
               gain <= 9'd0;
               if (enable)
                  st <= RAMP_UP;
            end
            RAMP_UP: begin
               if (!enable) begin
                  st <= RAMP_DOWN;
               end else if (up_sum >= 10'd256) begin
                  gain <= FULL;
                  st   <= PLAY;
               end else begin
                  gain <= up_sum[8:0];
               end
            end
            PLAY: begin
               gain <= FULL;
               if (!enable)
                  st <= RAMP_DOWN;
            end
            RAMP_DOWN: begin
               if (enable) begin
                  st <= RAMP_UP;
               end else if (gain <= STEP) begin
                  gain <= 9'd0;
                  st   <= MUTED;
               end else begin
                  gain <= gain - STEP;
               end
            end
         endcase
      end
   end

   assign cur_left_x  = {{10{cur_left[15]}}, cur_left};
   assign cur_right_x = {{10{cur_right[15]}}, cur_right};
   assign gain_x      = {16'd0, 1'b0, gain};
   assign prod_left   = cur_left_x * gain_x;
   assign prod_right  = cur_right_x * gain_x;

   assign scaled_left  = prod_left[23:8];
   assign scaled_right = prod_right[23:8];
   assign unused_bits  = ^{prod_left[25:24], prod_left[7:0],
                           prod_right[25:24], prod_right[7:0]};

   // offset binary: full negative maps to 0, full positive to 65535
   assign u_left    = {~scaled_left[15], scaled_left[14:0]};
   assign u_right   = {~scaled_right[15], scaled_right[14:0]};
   assign sum_left  = {1'b0, acc_left} + {1'b0, u_left};
   assign sum_right = {1'b0, acc_right} + {1'b0, u_right};

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         acc_left      <= '0;
         acc_right     <= '0;
         dac_left_pos  <= 1'b0;
         dac_left_neg  <= 1'b1;
         dac_right_pos <= 1'b0;
         dac_right_neg <= 1'b1;
      end else begin
         acc_left      <= sum_left[15:0];
         acc_right     <= sum_right[15:0];
         dac_left_pos  <= sum_left[16];
         dac_left_neg  <= ~sum_left[16];
         dac_right_pos <= sum_right[16];
         dac_right_neg <= ~sum_right[16];
      end
   end

endmodule

// File: tb/tb_kosei_sdm_dac.sv
// Randomized bench for kosei_sdm_dac against a transaction-level model.
// Modulator expectation: cumulative ones = floor(sum of inputs / 65536).
module tb_kosei_sdm_dac;

   localparam int OSR  = 4;
   localparam int STEP = 64;

   logic        clk_sys = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] sample_left = '0;
   logic [15:0] sample_right = '0;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic        underrun_clear = 1'b0;
   logic        dac_left_pos;
   logic        dac_left_neg;
   logic        dac_right_pos;
   logic        dac_right_neg;
   logic        sample_tick;
   logic [1:0]  mute_state;
   logic [8:0]  gain;
   logic        underrun_flag;
   logic [7:0]  underrun_count;

   kosei_sdm_dac #(.OSR(OSR), .RAMP_STEP(STEP)) dut (
      .clk_sys        (clk_sys),
      .rst_n          (rst_n),
      .enable         (enable),
      .sample_left    (sample_left),
      .sample_right   (sample_right),
      .sample_valid   (sample_valid),
      .sample_ready   (sample_ready),
      .underrun_clear (underrun_clear),
      .dac_left_pos   (dac_left_pos),
      .dac_left_neg   (dac_left_neg),
      .dac_right_pos  (dac_right_pos),
      .dac_right_neg  (dac_right_neg),
      .sample_tick    (sample_tick),
      .mute_state     (mute_state),
      .gain           (gain),
      .underrun_flag  (underrun_flag),
      .underrun_count (underrun_count)
   );

   always #5 clk_sys = ~clk_sys;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   logic [31:0] mq[$];
   int     m_cnt, m_cur_l, m_cur_r, m_gain, m_st, m_ucnt;
   bit     m_uflag;
   longint tot_l, tot_r, prv_l, prv_r;

   int          v_pct, clr_pm, en_mode;
   bit          const_mode, pend;
   logic [15:0] const_l, const_r;
   int          win_l, win_r;

   task automatic m_reset();
      mq.delete();
      m_cnt = 0; m_cur_l = 0; m_cur_r = 0;
      m_gain = 0; m_st = 0; m_ucnt = 0; m_uflag = 0;
      tot_l = 0; tot_r = 0; prv_l = 0; prv_r = 0;
      pend = 0;
   endtask

   function automatic int to_u(input int cur, input int g);
      int sc;
      sc = (cur * g) >>> 8;
      return (sc + 32768) & 65535;
   endfunction

   task automatic check_outputs();
      int bl, br;
      bl = int'((tot_l >> 16) - (prv_l >> 16));
      br = int'((tot_r >> 16) - (prv_r >> 16));
      chk("ready", sample_ready, mq.size() < 2);
      chk("tick", sample_tick, m_cnt == OSR - 1);
      chk("gain", gain, m_gain);
      chk("state", mute_state, m_st);
      chk("uflag", underrun_flag, m_uflag);
      chk("ucnt", underrun_count, m_ucnt);
      chk("pos_l", dac_left_pos, bl);
      chk("neg_l", dac_left_neg, 1 - bl);
      chk("pos_r", dac_right_pos, br);
      chk("neg_r", dac_right_neg, 1 - br);
   endtask

   task automatic model_edge();
      bit tk, psh;
      logic [31:0] e;
      logic signed [15:0] tl, tr;
      tk  = (m_cnt == OSR - 1);
      psh = sample_valid && (mq.size() < 2);
      prv_l = tot_l;
      prv_r = tot_r;
      tot_l += to_u(m_cur_l, m_gain);
      tot_r += to_u(m_cur_r, m_gain);
      if (tk) begin
         if (mq.size() > 0) begin
            e = mq.pop_front();
            tl = e[31:16];
            tr = e[15:0];
            m_cur_l = tl;
            m_cur_r = tr;
         end else begin
            m_uflag = 1;
            if (m_ucnt < 255) m_ucnt++;
         end
         case (m_st)
            0: begin
               m_gain = 0;
               if (enable) m_st = 1;
            end
            1: begin
               if (!enable) m_st = 3;
               else begin
                  m_gain = (m_gain + STEP > 256) ? 256 : m_gain + STEP;
                  if (m_gain == 256) m_st = 2;
               end
            end
            2: if (!enable) m_st = 3;
            default: begin
               if (enable) m_st = 1;
               else begin
                  m_gain = (m_gain - STEP < 0) ? 0 : m_gain - STEP;
                  if (m_gain == 0) m_st = 0;
               end
            end
         endcase
      end
      if (underrun_clear) begin
         m_uflag = 0;
         m_ucnt = 0;
      end
      if (psh) mq.push_back({sample_left, sample_right});
      m_cnt = (m_cnt + 1) % OSR;
   endtask

   task automatic step();
      bit ready_m;
      check_outputs();
      win_l += int'(dac_left_pos);
      win_r += int'(dac_right_pos);
      ready_m = (mq.size() < 2);
      if (!pend) begin
         sample_valid = (int'($urandom_range(99)) < v_pct);
         if (const_mode) begin
            sample_left  = const_l;
            sample_right = const_r;
         end else begin
            sample_left  = 16'($urandom);
            sample_right = 16'($urandom);
         end
      end
      if (en_mode == 2) begin
         if ($urandom_range(39) == 0) enable = ~enable;
      end else begin
         enable = (en_mode == 1);
      end
      underrun_clear = (int'($urandom_range(999)) < clr_pm);
      pend = sample_valid && !ready_m;
      model_edge();
      @(negedge clk_sys);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic mid_reset();
      #2 rst_n = 1'b0;
      #1;
      m_reset();
      sample_valid = 1'b0;
      underrun_clear = 1'b0;
      check_outputs();
      @(negedge clk_sys);
      @(negedge clk_sys);
      rst_n = 1'b1;
   endtask

   initial begin
      m_reset();
      v_pct = 90; clr_pm = 5; en_mode = 1; const_mode = 0;
      const_l = '0; const_r = '0;
      win_l = 0; win_r = 0;
      @(negedge clk_sys);
      check_outputs();
      @(negedge clk_sys);
      rst_n = 1'b1;

      run(3000);

      const_mode = 1; const_l = 16'h0000; const_r = 16'h0000;
      v_pct = 100; clr_pm = 0;
      run(400);
      win_l = 0; win_r = 0;
      run(1024);
      chk("half_ones_l", win_l, 512);
      chk("half_ones_r", win_r, 512);

      const_l = 16'h8000; const_r = 16'h7FFF;
      run(400);
      win_l = 0; win_r = 0;
      run(1024);
      chk("full_neg_ones", win_l, 0);
      chk("full_pos_ones", win_r >= 1023, 1);

      v_pct = 0;
      run(40);
      clr_pm = 1000;
      run(1);
      clr_pm = 0;
      run(12);
      chk("ucnt_three", underrun_count, 3);
      chk("uflag_set", underrun_flag, 1);
      clr_pm = 1000;
      run(1);
      clr_pm = 0;
      chk("ucnt_clr", underrun_count, 0);
      chk("uflag_clr", underrun_flag, 0);
      run(1300);
      chk("ucnt_sat", underrun_count, 255);

      const_mode = 0; v_pct = 80;
      run(57);
      mid_reset();
      chk("rst_gain", gain, 0);
      chk("rst_state", mute_state, 0);

      en_mode = 2; v_pct = 60; clr_pm = 10;
      run(4000);
      v_pct = 30;
      run(3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
